// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for one single-port, variable-latency memory bus (data wins, fetch anti-starvation).
// Optional hung-access abort after TIMEOUT busy cycles: define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_sel,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_if,
  output logic                stallreq_mem
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_starveCnt;
  logic                r_memCe;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [SEL_W-1:0]    r_memSel;
  logic [DATA_W-1:0]   r_memWdata;
  logic                r_iAck;
  logic                r_dAck;
  logic [DATA_W-1:0]   r_iRdata;
  logic [DATA_W-1:0]   r_dRdata;
  logic                w_iElig;
  logic                w_dElig;
  logic                w_grantI;
  logic                w_grantD;
  logic                w_done;
  logic                w_abort;
  logic                w_finish;

  assign i_ack        = r_iAck;
  assign d_ack        = r_dAck;
  assign i_rdata      = r_iRdata;
  assign d_rdata      = r_dRdata;
  assign mem_ce       = r_memCe;
  assign mem_we       = r_memWe;
  assign mem_addr     = r_memAddr;
  assign mem_sel      = r_memSel;
  assign mem_wdata    = r_memWdata;
  assign stallreq_if  = i_req & ~r_iAck;
  assign stallreq_mem = d_req & ~r_dAck;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmoCnt;
  logic             r_iErr;
  logic             r_dErr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmoCnt <= '0;
      r_iErr   <= 1'b0;
      r_dErr   <= 1'b0;
    end else begin
      r_tmoCnt <= (r_state == IDLE) ? '0 : r_tmoCnt + 1'b1;
      r_iErr   <= w_abort & (r_state == BUSY_I);
      r_dErr   <= w_abort & (r_state == BUSY_D);
    end
  end

  // A simultaneous mem_ack on the last allowed cycle still counts as a normal completion.
  assign w_abort = (r_state != IDLE) & ~mem_ack & (r_tmoCnt == TMO_W'(TIMEOUT - 1));
  assign i_err   = r_iErr;
  assign d_err   = r_dErr;
`else
  assign w_abort = 1'b0;
  assign i_err   = 1'b0;
  assign d_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // A request seen in the same cycle as its own ack is stale and never eligible.
  always_comb begin
    w_iElig     = i_req & ~r_iAck;
    w_dElig     = d_req & ~r_dAck;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    w_done      = 1'b0;
    w_finish    = 1'b0;
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_dElig && !(w_iElig && r_starveCnt == 4'(STARVE_LIMIT))) begin
          w_grantD    = 1'b1;
          w_nextState = BUSY_D;
        end else if (w_iElig) begin
          w_grantI    = 1'b1;
          w_nextState = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        w_done   = mem_ack;
        w_finish = mem_ack | w_abort;
        if (w_finish) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memCe    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memSel   <= '0;
      r_memWdata <= '0;
    end else if (w_grantD) begin
      r_memCe    <= 1'b1;
      r_memWe    <= d_we;
      r_memAddr  <= d_addr;
      r_memSel   <= d_sel;
      r_memWdata <= d_wdata;
    end else if (w_grantI) begin
      r_memCe    <= 1'b1;
      r_memWe    <= 1'b0;
      r_memAddr  <= i_addr;
      r_memSel   <= '1;
      r_memWdata <= '0;
    end else if (w_finish) begin
      r_memCe    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iAck   <= 1'b0;
      r_dAck   <= 1'b0;
      r_iRdata <= '0;
      r_dRdata <= '0;
    end else begin
      r_iAck <= w_finish & (r_state == BUSY_I);
      r_dAck <= w_finish & (r_state == BUSY_D);
      if (w_done && r_state == BUSY_I)       r_iRdata <= mem_rdata;
      else if (w_abort && r_state == BUSY_I) r_iRdata <= '0;
      if (w_done && r_state == BUSY_D)       r_dRdata <= mem_rdata;
      else if (w_abort && r_state == BUSY_D) r_dRdata <= '0;
    end
  end

  // Counts data grants that a pending fetch had to sit through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starveCnt <= 4'd0;
    end else if (w_grantI || !i_req) begin
      r_starveCnt <= 4'd0;
    end else if (w_grantD && r_starveCnt < 4'(STARVE_LIMIT)) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

endmodule
